// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register plus single-port program memory, one-cycle PC-to-output latency.
// stall freezes all fetch state; branch_taken always wins and redirects even while stalled or disabled.
module inst_fetch #(
    parameter int          DEPTH    = 64,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_en,
    input  logic                     stall,
    input  logic                     branch_taken,
    input  logic [31:0]              branch_target,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [31:0]              prog_data,
    output logic [31:0]              instruction_code,
    output logic [31:0]              pc_out,
    output logic                     valid,
    output logic                     misaligned
);

    localparam int          AW  = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] r_mem [DEPTH];

    logic [31:0] r_pc;
    logic [31:0] r_pc_out;
    logic [31:0] r_instr;
    logic        r_valid;
    logic        r_misaligned;

    logic [AW-1:0] w_idx;
    logic [31:0]   w_rd_word;
    logic [31:0]   w_pc_inc;
    logic [31:0]   w_redirect_pc;
    logic          w_target_misaligned;

    // PC wraps naturally through 32-bit overflow; the index wraps by truncation.
    assign w_idx               = r_pc[AW+1:2];
    assign w_rd_word           = r_mem[w_idx];
    assign w_pc_inc            = r_pc + 32'd4;
    assign w_redirect_pc       = {branch_target[31:2], 2'b00};
    assign w_target_misaligned = (branch_target[1:0] != 2'b00);

    // Contents survive reset; reset only suppresses writes. Read-before-write falls out of
    // the non-blocking update, so a same-edge fetch sees the old word.
    always_ff @(posedge clk or posedge reset) begin
        if (!reset && prog_we) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_pc_out     <= 32'h0000_0000;
            r_instr      <= NOP;
            r_valid      <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= branch_taken && w_target_misaligned;
            if (branch_taken) begin
                r_pc    <= w_redirect_pc;
                r_instr <= NOP;
                r_valid <= 1'b0;
            end else if (!fetch_en) begin
                r_instr <= NOP;
                r_valid <= 1'b0;
            end else if (!stall) begin
                r_instr  <= w_rd_word;
                r_pc_out <= r_pc;
                r_valid  <= 1'b1;
                r_pc     <= w_pc_inc;
            end
        end
    end

    assign instruction_code = r_instr;
    assign pc_out           = r_pc_out;
    assign valid            = r_valid;
    assign misaligned       = r_misaligned;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, fetch, stall, redirect, disable, wrap, read-before-write, async reset.
module tb_inst_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        prog_we;
    logic [5:0]  prog_addr;
    logic [31:0] prog_data;
    logic [31:0] instruction_code;
    logic [31:0] pc_out;
    logic        valid;
    logic        misaligned;

    int checks   = 0;
    int failures = 0;

    inst_fetch #(.DEPTH(64), .RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .reset            (reset),
        .fetch_en         (fetch_en),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .prog_we          (prog_we),
        .prog_addr        (prog_addr),
        .prog_data        (prog_data),
        .instruction_code (instruction_code),
        .pc_out           (pc_out),
        .valid            (valid),
        .misaligned       (misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic prog_write(input logic [5:0] a, input logic [31:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        if (pc_out !== 32'h0) begin failures++; $display("FAIL rst_pc_out got=%h exp=00000000", pc_out); end
        checks++;
        if (instruction_code !== NOP) begin failures++; $display("FAIL rst_instr got=%h exp=%h", instruction_code, NOP); end
        checks++;
        if (valid !== 1'b0 || misaligned !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", valid, misaligned); end
        checks++;
        tick();
        tick();
        reset = 1'b0;
        prog_write(6'd0,  32'h015A04B3);
        prog_write(6'd1,  32'h00000013);
        prog_write(6'd2,  32'h11111111);
        prog_write(6'd3,  32'h22222222);
        prog_write(6'd5,  32'h55555555);
        prog_write(6'd63, 32'h3F3F3F3F);
        if (valid !== 1'b0 || pc_out !== 32'h0) begin failures++; $display("FAIL load_idle got=%b/%h exp=0/00000000", valid, pc_out); end
        checks++;
    endtask

    task automatic test_fetch_stall;
        fetch_en = 1'b1;
        tick();
        if (instruction_code !== 32'h015A04B3 || pc_out !== 32'h0 || valid !== 1'b1) begin
            failures++; $display("FAIL fetch1 got=%h/%h/%b exp=015a04b3/00000000/1", instruction_code, pc_out, valid);
        end
        checks++;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (instruction_code !== 32'h015A04B3 || pc_out !== 32'h0 || valid !== 1'b1) begin
                failures++; $display("FAIL stall_hold%0d got=%h/%h/%b exp=015a04b3/00000000/1", i, instruction_code, pc_out, valid);
            end
            checks++;
        end
        stall = 1'b0;
        tick();
        if (instruction_code !== 32'h00000013 || pc_out !== 32'h4 || valid !== 1'b1) begin
            failures++; $display("FAIL fetch2 got=%h/%h/%b exp=00000013/00000004/1", instruction_code, pc_out, valid);
        end
        checks++;
    endtask

    task automatic test_branch;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_000A;
        stall         = 1'b1;
        tick();
        if (valid !== 1'b0 || instruction_code !== NOP || misaligned !== 1'b1 || pc_out !== 32'h4) begin
            failures++; $display("FAIL br_redirect got=%b/%h/%b/%h exp=0/00000013/1/00000004", valid, instruction_code, misaligned, pc_out);
        end
        checks++;
        branch_taken = 1'b0;
        stall        = 1'b0;
        tick();
        if (pc_out !== 32'h8 || valid !== 1'b1 || misaligned !== 1'b0 || instruction_code !== 32'h11111111) begin
            failures++; $display("FAIL br_target got=%h/%b/%b/%h exp=00000008/1/0/11111111", pc_out, valid, misaligned, instruction_code);
        end
        checks++;
    endtask

    task automatic test_disable;
        fetch_en = 1'b0;
        tick();
        if (valid !== 1'b0 || instruction_code !== NOP || pc_out !== 32'h8) begin
            failures++; $display("FAIL dis_idle got=%b/%h/%h exp=0/00000013/00000008", valid, instruction_code, pc_out);
        end
        checks++;
        fetch_en = 1'b1;
        tick();
        if (pc_out !== 32'hC || instruction_code !== 32'h22222222 || valid !== 1'b1) begin
            failures++; $display("FAIL dis_resume got=%h/%h/%b exp=0000000c/22222222/1", pc_out, instruction_code, valid);
        end
        checks++;
    endtask

    task automatic test_wrap;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_00FC;
        tick();
        if (misaligned !== 1'b0 || valid !== 1'b0 || pc_out !== 32'hC) begin
            failures++; $display("FAIL wrap_redirect got=%b/%b/%h exp=0/0/0000000c", misaligned, valid, pc_out);
        end
        checks++;
        branch_taken = 1'b0;
        tick();
        if (pc_out !== 32'hFC || instruction_code !== 32'h3F3F3F3F) begin
            failures++; $display("FAIL wrap_idx63 got=%h/%h exp=000000fc/3f3f3f3f", pc_out, instruction_code);
        end
        checks++;
        tick();
        if (pc_out !== 32'h100 || instruction_code !== 32'h015A04B3) begin
            failures++; $display("FAIL wrap_idx0 got=%h/%h exp=00000100/015a04b3", pc_out, instruction_code);
        end
        checks++;
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        tick();
        if (pc_out !== 32'hFFFFFFFC || instruction_code !== 32'h3F3F3F3F) begin
            failures++; $display("FAIL pc_top got=%h/%h exp=fffffffc/3f3f3f3f", pc_out, instruction_code);
        end
        checks++;
        tick();
        if (pc_out !== 32'h0 || instruction_code !== 32'h015A04B3) begin
            failures++; $display("FAIL pc_wrap got=%h/%h exp=00000000/015a04b3", pc_out, instruction_code);
        end
        checks++;
    endtask

    task automatic test_read_before_write;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0008;
        fetch_en      = 1'b0;
        tick();
        if (valid !== 1'b0 || instruction_code !== NOP) begin
            failures++; $display("FAIL rbw_redirect_disabled got=%b/%h exp=0/00000013", valid, instruction_code);
        end
        checks++;
        branch_taken = 1'b0;
        fetch_en     = 1'b1;
        prog_we      = 1'b1;
        prog_addr    = 6'd2;
        prog_data    = 32'hDEADBEEF;
        tick();
        prog_we = 1'b0;
        if (instruction_code !== 32'h11111111 || pc_out !== 32'h8) begin
            failures++; $display("FAIL rbw_old got=%h/%h exp=11111111/00000008", instruction_code, pc_out);
        end
        checks++;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0008;
        tick();
        branch_taken = 1'b0;
        tick();
        if (instruction_code !== 32'hDEADBEEF || pc_out !== 32'h8) begin
            failures++; $display("FAIL rbw_new got=%h/%h exp=deadbeef/00000008", instruction_code, pc_out);
        end
        checks++;
    endtask

    task automatic test_async_reset;
        tick();
        if (instruction_code !== 32'h22222222 || pc_out !== 32'hC) begin
            failures++; $display("FAIL ar_pre got=%h/%h exp=22222222/0000000c", instruction_code, pc_out);
        end
        checks++;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0015;
        stall         = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        if (pc_out !== 32'h0 || instruction_code !== NOP || valid !== 1'b0 || misaligned !== 1'b0) begin
            failures++; $display("FAIL ar_async got=%h/%h/%b/%b exp=00000000/00000013/0/0", pc_out, instruction_code, valid, misaligned);
        end
        checks++;
        prog_we   = 1'b1;
        prog_addr = 6'd5;
        prog_data = 32'hBAD0BAD0;
        tick();
        if (misaligned !== 1'b0 || valid !== 1'b0) begin
            failures++; $display("FAIL ar_held got=%b/%b exp=0/0", misaligned, valid);
        end
        checks++;
        prog_we      = 1'b0;
        branch_taken = 1'b0;
        stall        = 1'b0;
        fetch_en     = 1'b0;
        reset        = 1'b0;
        tick();
        if (valid !== 1'b0 || pc_out !== 32'h0 || instruction_code !== NOP) begin
            failures++; $display("FAIL ar_disabled got=%b/%h/%h exp=0/00000000/00000013", valid, pc_out, instruction_code);
        end
        checks++;
        fetch_en = 1'b1;
        tick();
        if (pc_out !== 32'h0 || instruction_code !== 32'h015A04B3 || valid !== 1'b1) begin
            failures++; $display("FAIL ar_first_fetch got=%h/%h/%b exp=00000000/015a04b3/1", pc_out, instruction_code, valid);
        end
        checks++;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0014;
        tick();
        branch_taken = 1'b0;
        tick();
        if (pc_out !== 32'h14 || instruction_code !== 32'h55555555) begin
            failures++; $display("FAIL ar_write_blocked got=%h/%h exp=00000014/55555555", pc_out, instruction_code);
        end
        checks++;
    endtask

    initial begin
        reset         = 1'b1;
        fetch_en      = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        prog_we       = 1'b0;
        prog_addr     = 6'd0;
        prog_data     = 32'h0;
        test_reset();
        test_fetch_stall();
        test_branch();
        test_disable();
        test_wrap();
        test_read_before_write();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter DEPTH, default 64, SHALL set the number of 32-bit words in the internal instruction memory (power of two, 16..1024).
REQ-002 Parameter RESET_PC, default 32'h00000000, SHALL set the PC value loaded on reset (word-aligned).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 fetch_en  input  1  SHALL enable fetching when high.
REQ-006 stall  input  1  SHALL freeze all fetch state when high (downstream not ready).
REQ-007 branch_taken  input  1  SHALL request a redirect of the PC to branch_target.
REQ-008 branch_target  input  32  SHALL be the redirect address.
REQ-009 prog_we  input  1  SHALL be the program-load write enable.
REQ-010 prog_addr  input  log2(DEPTH)  SHALL be the program-load word index.
REQ-011 prog_data  input  32  SHALL be the program-load word.
REQ-012 instruction_code  output  32  SHALL be the fetched instruction, feeding the decoder's instruction_code input.
REQ-013 pc_out  output  32  SHALL be the address of the word in instruction_code.
REQ-014 valid  output  1  SHALL be high when instruction_code/pc_out hold a real fetched instruction.
REQ-015 misaligned  output  1  SHALL pulse high for one cycle when an accepted redirect has branch_target[1:0] != 0.

Function
REQ-016 Internal PC register; memory index = pc[log2(DEPTH)+1:2]. Indices wrap modulo DEPTH; PC itself wraps 32'hFFFFFFFC -> 32'h0.
REQ-017 Per-edge priority SHALL be: branch_taken > !fetch_en > stall > normal fetch.
REQ-018 Normal fetch (fetch_en=1, stall=0, branch_taken=0): instruction_code <= mem[index(pc)], pc_out <= pc, valid <= 1, pc <= pc + 4; latency from PC to output is one cycle.
REQ-019 Stall (fetch_en=1, stall=1, branch_taken=0): pc, instruction_code, pc_out, valid SHALL all hold.
REQ-020 Disabled (fetch_en=0, branch_taken=0): pc and pc_out hold; valid <= 0; instruction_code <= 32'h00000013 (NOP).
REQ-021 Redirect (branch_taken=1, regardless of stall/fetch_en): pc <= {branch_target[31:2], 2'b00}; valid <= 0; instruction_code <= 32'h00000013; pc_out holds.
REQ-022 misaligned <= (branch_taken && branch_target[1:0] != 0); otherwise 0.
REQ-023 Program write: on an edge with prog_we=1, mem[prog_addr] <= prog_data, independent of fetch/stall/branch state.
REQ-024 Same-edge write and fetch of the same index SHALL return the old word (read-before-write); the new word is visible from the next fetch.
REQ-025 Memory contents SHALL NOT be cleared by reset; an unwritten word reads X in simulation.
REQ-026 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-027 On reset assertion, immediately and without a clock: pc = RESET_PC, pc_out = 32'h0, instruction_code = 32'h00000013, valid = 0, misaligned = 0.
REQ-028 While reset is high, prog_we writes SHALL be ignored.
REQ-029 After reset deasserts, the first qualifying edge SHALL fetch from RESET_PC.
REQ-030 Reset asserted mid-stall or mid-redirect SHALL discard that state; no pending redirect survives reset.

Verification
REQ-031 Load mem[0]=32'h015A04B3, mem[1]=32'h00000013; release reset with fetch_en=1 -> edge 1: instruction_code=32'h015A04B3, pc_out=0, valid=1; edge 2: 32'h00000013, pc_out=4.
REQ-032 stall=1 for 3 edges after edge 1 of REQ-031 -> outputs remain 32'h015A04B3 / pc_out=0 / valid=1; resume gives pc_out=4.
REQ-033 branch_taken=1, branch_target=32'h0000000A together with stall=1 -> next edge valid=0, instruction_code=NOP, misaligned=1; following edge pc_out=8, valid=1, misaligned=0.
REQ-034 DEPTH=64, PC at 32'h000000FC -> fetch of index 63, then pc_out=32'h00000100 returns mem[0].
REQ-035 prog_we=1 to index 2 with 32'hDEADBEEF on the same edge PC fetches index 2 -> old word returned; after redirect to 8, 32'hDEADBEEF returned.
REQ-036 Assert reset asynchronously between edges during normal fetch -> outputs take REQ-027 values before the next edge; fetch_en=0 afterwards keeps valid=0.
